// File: rtl/led_blinker_bank.sv
// rtl/led_blinker_bank.sv - bank of independent LED blink channels sharing one LFSR
//
// Purpose: NUM_CH LED channels.
//   Each channel is off, fixed-period, random-period or solid on.
//   Random periods come from a shared Fibonacci LFSR.
// Ports:
//   clk        - single clock, posedge only
//   rstbtn     - asynchronous active-high reset
//   en         - global enable; low freezes counters and the LFSR and blanks LEDs
//   cfg_load   - per-channel strobe latching mode/interval
//   mode       - 2 bits per channel: 00 off, 01 fixed, 10 random, 11 solid
//   interval   - CNT_W bits per channel, fixed-mode period value
//   led        - registered LED drive
//   lfsr_state - current LFSR value
module led_blinker_bank #(
    parameter int                NUM_CH    = 3,
    parameter int                CNT_W     = 8,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rstbtn,
    input  logic                    en,
    input  logic [NUM_CH-1:0]       cfg_load,
    input  logic [2*NUM_CH-1:0]     mode,
    input  logic [NUM_CH*CNT_W-1:0] interval,
    output logic [NUM_CH-1:0]       led,
    output logic [LFSR_W-1:0]       lfsr_state
);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_FIXED = 2'b01;
    localparam logic [1:0] MODE_RAND  = 2'b10;
    localparam logic [1:0] MODE_SOLID = 2'b11;

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic              lfsr_fb;

    always_comb begin
        lfsr_fb = ^(lfsr_q & LFSR_TAPS);
        lfsr_d  = lfsr_q;
        if (lfsr_q == '0) begin
            // The all-zero state is a fixed point of the LFSR.
            // Escape it by reloading the seed.
            lfsr_d = LFSR_SEED;
        end else if (en) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_fb};
        end
    end

    always_ff @(posedge clk or posedge rstbtn) begin
        if (rstbtn) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_state = lfsr_q;

    // Each channel rotates the shared LFSR by its index.
    // This gives channels loaded on the same edge different periods.
    // A zero draw is bumped to 1 so that the random period never collapses to "every cycle".
    function automatic logic [CNT_W-1:0] rand_for(input logic [LFSR_W-1:0] s,
                                                  input int unsigned       sh);
        logic [2*LFSR_W-1:0] dbl;
        logic [CNT_W-1:0]    r;
        dbl = {s, s} << sh;
        r   = dbl[LFSR_W +: CNT_W];
        if (r == '0) begin
            r = {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [1:0]       mode_q, mode_d, mode_in;
        logic [CNT_W-1:0] cnt_q, cnt_d, per_q, per_d;
        logic [CNT_W-1:0] interval_in, rand_i;
        logic             led_q, led_d, hit;

        assign mode_in     = mode[2*i +: 2];
        assign interval_in = interval[i*CNT_W +: CNT_W];
        assign rand_i      = rand_for(lfsr_q, i);
        assign hit         = (cnt_q == per_q);

        always_comb begin
            mode_d = mode_q;
            cnt_d  = cnt_q;
            per_d  = per_q;
            led_d  = 1'b0;
            if (cfg_load[i]) begin
                // A load restarts the channel.
                // It also swallows any pulse due on this edge.
                mode_d = mode_in;
                cnt_d  = '0;
                unique case (mode_in)
                    MODE_FIXED: per_d = interval_in;
                    MODE_RAND:  per_d = rand_i;
                    default:    per_d = '0;
                endcase
            end else if (en) begin
                unique case (mode_q)
                    MODE_OFF: begin
                        cnt_d = '0;
                    end
                    MODE_SOLID: begin
                        led_d = 1'b1;
                        cnt_d = '0;
                    end
                    MODE_FIXED, MODE_RAND: begin
                        led_d = hit;
                        cnt_d = hit ? '0 : cnt_q + 1'b1;
                        if (hit && mode_q == MODE_RAND) begin
                            per_d = rand_i;
                        end
                    end
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk or posedge rstbtn) begin
            if (rstbtn) begin
                mode_q <= MODE_OFF;
                cnt_q  <= '0;
                per_q  <= '0;
                led_q  <= 1'b0;
            end else begin
                mode_q <= mode_d;
                cnt_q  <= cnt_d;
                per_q  <= per_d;
                led_q  <= led_d;
            end
        end

        assign led[i] = led_q;
    end

endmodule

// File: tb/tb_led_blinker_bank.sv
// tb/tb_led_blinker_bank.sv - directed self-checking bench for led_blinker_bank
module tb_led_blinker_bank;

    logic        clk = 1'b0;
    logic        rstbtn;
    logic        en;
    logic [2:0]  cfg_load;
    logic [5:0]  mode;
    logic [23:0] interval;
    logic [2:0]  led;
    logic [15:0] lfsr_state;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] m_lfsr;
    logic [15:0] pre_lfsr;
    logic [15:0] frozen;
    int          gap;
    int          exp_gap;
    int          hits;

    led_blinker_bank dut (
        .clk        (clk),
        .rstbtn     (rstbtn),
        .en         (en),
        .cfg_load   (cfg_load),
        .mode       (mode),
        .interval   (interval),
        .led        (led),
        .lfsr_state (lfsr_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Taps of x^16+x^14+x^13+x^11+1 are bits 15,13,12,10.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        if (s == 16'h0) return 16'hACE1;
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Rotating left by 2 puts s[5:0],s[15:14] into the low byte.
    function automatic int rand2(input logic [15:0] s);
        logic [7:0] r;
        r = {s[5:0], s[15:14]};
        return (r == 8'h0) ? 1 : int'(r);
    endfunction

    task automatic tick();
        @(posedge clk);
        pre_lfsr = m_lfsr;
        if (en && !rstbtn) m_lfsr = lfsr_step(m_lfsr);
        @(negedge clk);
    endtask

    initial begin
        rstbtn   = 1'b1;
        en       = 1'b0;
        cfg_load = 3'b000;
        mode     = 6'b0;
        interval = 24'h0;
        m_lfsr   = 16'hACE1;
        pre_lfsr = 16'hACE1;
        repeat (2) @(negedge clk);
        chk("reset_led", led, 3'b000);
        chk("reset_lfsr", lfsr_state, 16'hACE1);

        // Idle: the LFSR runs, but no channel lights without a load.
        rstbtn = 1'b0;
        en     = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("idle_led", led, 3'b000);
            chk("idle_lfsr", lfsr_state, m_lfsr);
        end

        // ch0 fixed 9 and ch1 fixed 4.
        // Inputs change afterwards, which must have no effect.
        mode     = {2'b00, 2'b01, 2'b01};
        interval = {8'd0, 8'd4, 8'd9};
        cfg_load = 3'b011;
        tick();
        cfg_load = 3'b000;
        mode     = 6'b111111;
        interval = 24'hFFFFFF;
        chk("fixed_load_edge", led, 3'b000);
        for (int k = 1; k <= 30; k++) begin
            tick();
            chk("fixed_pulses", led, {1'b0, (k % 5) == 0, (k % 10) == 0});
        end

        // ch2 random; ch0 and ch1 off.
        mode     = {2'b10, 2'b00, 2'b00};
        cfg_load = 3'b111;
        tick();
        cfg_load = 3'b000;
        exp_gap  = rand2(pre_lfsr) + 1;
        gap      = 0;
        hits     = 0;
        for (int c = 0; c < 4000 && hits < 9; c++) begin
            tick();
            gap++;
            if (led[2]) begin
                chk("rand_gap", gap, exp_gap);
                exp_gap = rand2(pre_lfsr) + 1;
                gap     = 0;
                hits++;
            end
        end
        chk("rand_hits", hits, 9);
        chk("rand_lfsr", lfsr_state, m_lfsr);

        // ch0 fixed 9 and ch1 solid, with en dropped after 6 enabled edges.
        // cnt0 holds at 6, so 4 enabled edges remain until the pulse.
        mode     = {2'b00, 2'b11, 2'b01};
        interval = {8'd0, 8'd0, 8'd9};
        cfg_load = 3'b111;
        tick();
        cfg_load = 3'b000;
        chk("pause_load_edge", led, 3'b000);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("pause_pre", led, 3'b010);
        end
        en     = 1'b0;
        frozen = m_lfsr;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("pause_led", led, 3'b000);
            chk("pause_lfsr", lfsr_state, frozen);
        end
        en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("pause_resume", led, {1'b0, 1'b1, k == 4});
        end

        // ch1 fixed 4, then reloaded on the edge where its pulse is due.
        mode     = {2'b00, 2'b01, 2'b00};
        interval = {8'd0, 8'd4, 8'd0};
        cfg_load = 3'b010;
        tick();
        cfg_load = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("ld_pre", led[1], 1'b0);
        end
        cfg_load = 3'b010;
        tick();
        cfg_load = 3'b000;
        chk("ld_over_pulse", led[1], 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("ld_restart", led[1], k == 5);
        end

        // Interval 0: every enabled edge is a hit.
        interval = 24'h0;
        cfg_load = 3'b010;
        tick();
        cfg_load = 3'b000;
        chk("int0_load_edge", led[1], 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("int0_high", led[1], 1'b1);
        end

        mode     = {2'b00, 2'b11, 2'b00};
        cfg_load = 3'b010;
        tick();
        cfg_load = 3'b000;
        chk("solid_load_edge", led[1], 1'b0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("solid_high", led[1], 1'b1);
        end

        mode     = 6'b0;
        cfg_load = 3'b010;
        tick();
        cfg_load = 3'b000;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("off_low", led[1], 1'b0);
        end

        // Asynchronous reset between edges while ch1 is lit.
        mode     = {2'b00, 2'b11, 2'b00};
        cfg_load = 3'b010;
        tick();
        cfg_load = 3'b000;
        tick();
        chk("rst_pre_led", led[1], 1'b1);
        #2;
        rstbtn = 1'b1;
        #1;
        chk("rst_async_led", led, 3'b000);
        chk("rst_async_lfsr", lfsr_state, 16'hACE1);
        m_lfsr = 16'hACE1;
        @(negedge clk);
        rstbtn = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rst_after_led", led, 3'b000);
            chk("rst_after_lfsr", lfsr_state, m_lfsr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
